// File: rtl/prbs_pkg.sv
// prbs_pkg: polynomial select encoding and per-mode order/tap/mask lookup for the PRBS generator
package prbs_pkg;
  typedef enum logic [1:0] {PRBS7 = 2'd0, PRBS15 = 2'd1, PRBS23 = 2'd2, PRBS31 = 2'd3} prbs_mode_e;
  function automatic logic [4:0] mode_order(input logic [1:0] m);
    return m == PRBS7 ? 5'd7 : m == PRBS15 ? 5'd15 : m == PRBS23 ? 5'd23 : 5'd31;
  endfunction
  function automatic logic [4:0] mode_tap(input logic [1:0] m);
    return m == PRBS7 ? 5'd6 : m == PRBS15 ? 5'd14 : m == PRBS23 ? 5'd18 : 5'd28;
  endfunction
  function automatic logic [30:0] mode_mask(input logic [1:0] m);
    return m == PRBS7 ? 31'h7f : m == PRBS15 ? 31'h7fff : m == PRBS23 ? 31'h7f_ffff : 31'h7fff_ffff;
  endfunction
endpackage

// File: rtl/prbs_advance.sv
// prbs_advance: W unrolled Fibonacci LFSR steps of the selected polynomial in one cycle
//   state      in   31  current LFSR state (bits above order are zero)
//   mode       in   2   polynomial select
//   word       out  W   generated bits, bit W-1 is the earliest
//   state_next out  31  state after W steps
module prbs_advance
  import prbs_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [30:0]  state,
  input  logic [1:0]   mode,
  output logic [W-1:0] word,
  output logic [30:0]  state_next
);
  logic [30:0] s;
  logic        b;
  always_comb begin
    s = state;
    b = 1'b0;
    word = '0;
    for (int i = 0; i < W; i++) begin
      b = s[mode_order(mode) - 5'd1] ^ s[mode_tap(mode) - 5'd1];
      word[W-1-i] = b;
      s = {s[29:0], b} & mode_mask(mode);
    end
    state_next = s;
  end
endmodule

// File: rtl/prbs_word_gen.sv
// prbs_word_gen: W-bit PRBS word source with seed load, valid/ready output and error injection
//   clock, reset (sync, high); enable; mode/seed/seed_load; out_ready;
//   err_period/err_inject; out_data/out_valid/out_err; word_count (saturating)
module prbs_word_gen
  import prbs_pkg::*;
#(
  parameter int W            = 8,
  parameter int MODE_DEFAULT = 0,
  parameter int CNT_W        = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic [30:0]      seed,
  input  logic             seed_load,
  input  logic             out_ready,
  input  logic [15:0]      err_period,
  input  logic             err_inject,
  output logic [W-1:0]     out_data,
  output logic             out_valid,
  output logic             out_err,
  output logic [CNT_W-1:0] word_count
);
  localparam int PW = W > 1 ? $clog2(W) : 1;
  logic [30:0]   state, state_nx, seed_m;
  logic [1:0]    mode_q;
  logic [15:0]   ecnt;
  logic [PW-1:0] pos;
  logic [W-1:0]  word, flip;
  logic          pend, adv, per_hit, inj;
  prbs_advance #(.W(W)) u_adv (.state(state), .mode(mode_q), .word(word), .state_next(state_nx));
  assign adv = enable & (!out_valid | out_ready) & !seed_load;
  // >= rather than == so a period lowered below the running count fires on the next word
  assign per_hit = (err_period != 16'd0) && ({1'b0, ecnt} + 17'd1 >= {1'b0, err_period});
  assign inj = pend | err_inject;
  // pos tracks (index of the next generated word) mod W, words counted from 1
  assign flip = (per_hit ? W'(1) << pos : W'(0)) ^ W'(inj);
  assign seed_m = seed & mode_mask(mode);
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= mode_mask(2'(MODE_DEFAULT));
      mode_q <= 2'(MODE_DEFAULT);
      out_data <= '0;
      out_valid <= 1'b0;
      out_err <= 1'b0;
      word_count <= '0;
      ecnt <= '0;
      pend <= 1'b0;
      pos <= PW'(1 % W);
    end else if (seed_load) begin
      mode_q <= mode;
      state <= seed_m == 31'd0 ? mode_mask(mode) : seed_m;
      out_valid <= 1'b0;
      word_count <= '0;
      ecnt <= '0;
      pos <= PW'(1 % W);
      pend <= pend | err_inject;
    end else begin
      if (out_valid && out_ready && word_count != '1)
        word_count <= word_count + 1'b1;
      if (adv) begin
        out_data <= word ^ flip;
        out_valid <= 1'b1;
        out_err <= per_hit | inj;
        state <= state_nx;
        ecnt <= per_hit ? 16'd0 : err_period != 16'd0 ? ecnt + 16'd1 : ecnt;
        pos <= pos == PW'(W - 1) ? '0 : pos + 1'b1;
        pend <= 1'b0;
      end else begin
        out_valid <= out_valid & !out_ready;
        pend <= pend | err_inject;
      end
    end
  end
endmodule

// File: tb/tb_prbs_word_gen.sv
// tb_prbs_word_gen: randomized and directed checks of prbs_word_gen against a bit-history PRBS model
module tb_prbs_word_gen;
  localparam int W = 8;
  localparam int CNT_W = 32;
  logic clock = 0, reset = 1, enable = 0, seed_load = 0, out_ready = 0, err_inject = 0;
  logic [1:0] mode = 0;
  logic [30:0] seed = 0;
  logic [15:0] err_period = 0;
  logic [W-1:0] out_data;
  logic out_valid, out_err;
  logic [CNT_W-1:0] word_count;
  int total = 0, bad = 0;

  prbs_word_gen #(.W(W), .MODE_DEFAULT(0), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .enable(enable), .mode(mode), .seed(seed),
    .seed_load(seed_load), .out_ready(out_ready), .err_period(err_period),
    .err_inject(err_inject), .out_data(out_data), .out_valid(out_valid),
    .out_err(out_err), .word_count(word_count));

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad < 30) $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int ord(input int m);
    return m == 0 ? 7 : m == 1 ? 15 : m == 2 ? 23 : 31;
  endfunction
  function automatic int tapf(input int m);
    return m == 0 ? 6 : m == 1 ? 14 : m == 2 ? 18 : 28;
  endfunction

  // model: the sequence obeys b[k] = b[k-n] ^ b[k-t]; hist holds the last n bits, oldest first
  bit hist[$];
  int m_n, m_t;
  logic m_valid, m_err, m_pend;
  logic [W-1:0] m_data, m_clean;
  longint m_count;
  int m_ecnt, m_g;

  task automatic load_hist(input int m, input logic [30:0] sv);
    longint msk, sm;
    m_n = ord(m);
    m_t = tapf(m);
    msk = (64'd1 << m_n) - 1;
    sm = longint'(sv) & msk;
    if (sm == 0) sm = msk;
    hist.delete();
    for (int i = m_n - 1; i >= 0; i--) hist.push_back(sm[i]);
  endtask

  always @(posedge clock) begin
    bit b, hit, inj;
    logic [W-1:0] w;
    if (reset) begin
      load_hist(0, 31'h7fff_ffff);
      m_valid = 0; m_err = 0; m_pend = 0; m_data = 0; m_clean = 0;
      m_count = 0; m_ecnt = 0; m_g = 0;
    end else if (seed_load) begin
      load_hist(int'(mode), seed);
      m_valid = 0; m_count = 0; m_ecnt = 0; m_g = 0;
      m_pend = m_pend | err_inject;
    end else begin
      if (m_valid && out_ready && m_count < 64'hFFFF_FFFF) m_count++;
      if (enable && (!m_valid || out_ready)) begin
        for (int i = W - 1; i >= 0; i--) begin
          b = hist[0] ^ hist[m_n - m_t];
          hist.push_back(b);
          void'(hist.pop_front());
          w[i] = b;
        end
        m_clean = w;
        m_g++;
        hit = err_period != 0 && m_ecnt + 1 >= int'(err_period);
        if (hit) begin
          w[m_g % W] = ~w[m_g % W];
          m_ecnt = 0;
        end else if (err_period != 0) m_ecnt++;
        inj = m_pend || err_inject;
        if (inj) w[0] = ~w[0];
        m_err = hit || inj;
        m_pend = 0;
        m_data = w;
        m_valid = 1;
      end else begin
        if (out_ready) m_valid = 0;
        m_pend = m_pend | err_inject;
      end
    end
    #2;
    chk("valid", out_valid, m_valid);
    chk("count", word_count, m_count);
    if (m_valid) begin
      chk("data", out_data, m_data);
      chk("err", out_err, m_err);
    end
  end

  logic [W-1:0] wbuf[32771];
  logic [W-1:0] hold;
  logic [CNT_W-1:0] hcnt;
  int ones;

  initial begin
    repeat (3) @(negedge clock);
    reset = 0;
    @(negedge clock);
    chk("reset_valid", out_valid, 0);
    chk("reset_count", word_count, 0);
    enable = 1; out_ready = 1;
    @(negedge clock);
    chk("first_valid", out_valid, 1);
    chk("first_word", out_data, 8'h02);
    chk("model_first", m_data, 8'h02);
    @(negedge clock);
    chk("second_word", out_data, 8'h0C);
    chk("model_second", m_data, 8'h0C);
    // PRBS7 period: 127 words of 8 bits cover 8 full periods
    for (int k = 0; k < 131; k++) begin
      @(negedge clock);
      wbuf[k] = out_data;
    end
    ones = 0;
    for (int k = 0; k < 127; k++) ones += $countones(wbuf[k]);
    chk("prbs7_ones", ones, 512);
    for (int k = 0; k < 4; k++) chk("prbs7_repeat", wbuf[127 + k], wbuf[k]);
    // stall mid-stream
    out_ready = 0;
    @(negedge clock);
    hold = out_data; hcnt = word_count;
    repeat (5) @(negedge clock);
    chk("stall_data", out_data, hold);
    chk("stall_count", word_count, hcnt);
    out_ready = 1;
    repeat (4) @(negedge clock);
    // zero seed with PRBS31 falls back to all-ones
    seed = 0; mode = 3; seed_load = 1;
    @(negedge clock);
    seed_load = 0;
    chk("sl_valid", out_valid, 0);
    chk("sl_count", word_count, 0);
    @(negedge clock);
    chk("prbs31_first", out_data, 8'h00);
    repeat (40) @(negedge clock);
    // PRBS15 period
    seed = 31'($urandom); mode = 1; seed_load = 1;
    @(negedge clock);
    seed_load = 0;
    for (int k = 0; k < 32771; k++) begin
      @(negedge clock);
      wbuf[k] = out_data;
    end
    ones = 0;
    for (int k = 0; k < 32767; k++) ones += $countones(wbuf[k]);
    chk("prbs15_ones", ones, 131072);
    for (int k = 0; k < 4; k++) chk("prbs15_repeat", wbuf[32767 + k], wbuf[k]);
    // periodic injection every 4th word at bit (index mod W)
    seed = 31'h7f; mode = 0; seed_load = 1; err_period = 4;
    @(negedge clock);
    seed_load = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clock);
      chk("per_err", out_err, k % 4 == 0);
      chk("per_flip", out_data ^ m_clean, k % 4 == 0 ? 8'd1 << (k % 8) : 8'd0);
    end
    err_period = 0; err_inject = 1;
    @(negedge clock);
    err_inject = 0;
    chk("inj_flip", out_data ^ m_clean, 8'd1);
    chk("inj_err", out_err, 1);
    @(negedge clock);
    chk("inj_clear", out_err, 0);
    // randomized run
    for (int c = 0; c < 3000; c++) begin
      @(negedge clock);
      enable = $urandom_range(0, 9) != 0;
      out_ready = $urandom_range(0, 3) != 0;
      err_inject = $urandom_range(0, 40) == 0;
      seed_load = $urandom_range(0, 200) == 0;
      if (seed_load) begin
        mode = 2'($urandom);
        seed = $urandom_range(0, 3) == 0 ? 31'd0 : 31'($urandom);
      end
      if ($urandom_range(0, 150) == 0) err_period = 16'($urandom_range(0, 7));
    end
    // reset with a word held
    @(negedge clock);
    seed_load = 0; err_inject = 0; enable = 1; out_ready = 0;
    repeat (2) @(negedge clock);
    chk("pre_reset_valid", out_valid, 1);
    reset = 1;
    @(negedge clock);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_err", out_err, 0);
    chk("rst_count", word_count, 0);
    reset = 0;
    repeat (3) @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
